// File: rtl/fft_pkg.sv
// fft_pkg: shared float-format constants, streamer state encoding and index helpers.
package fft_pkg;
    localparam int FORMAT_WIDTH = 9;
    localparam int EXP_WIDTH    = 4;
    localparam int SIG_WIDTH    = FORMAT_WIDTH - EXP_WIDTH - 1;

    typedef enum logic [1:0] {LOAD, START, WAIT, UNLOAD} state_t;

    function automatic logic [31:0] bitrev(input logic [31:0] idx, input logic [7:0] log2n);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++)
            if (i < int'(log2n)) r[i] = idx[int'(log2n) - 1 - i];
        return r;
    endfunction

    function automatic logic is_legal_size(input logic [31:0] size, input logic [31:0] max);
        return size >= 32'd4 && size <= max && (size & (size - 32'd1)) == 32'd0;
    endfunction

    function automatic logic [7:0] size_log2(input logic [31:0] size);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 32; i++)
            if (size == (32'd1 << i)) r = 8'(i);
        return r;
    endfunction
endpackage

// File: rtl/frame_buffer.sv
// frame_buffer: N complex words {real, imag}; indexed write, whole-frame load, flat and indexed read.
module frame_buffer import fft_pkg::*; #(
    parameter int W  = FORMAT_WIDTH,
    parameter int N  = 32,
    parameter int IW = $clog2(N)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_wr_en,
    input  logic [IW-1:0] i_wr_idx,
    input  logic [W-1:0]  i_wr_real,
    input  logic [W-1:0]  i_wr_imag,
    input  logic          i_load_en,
    input  logic [N*W-1:0] i_load_real,
    input  logic [N*W-1:0] i_load_imag,
    input  logic [IW-1:0] i_rd_idx,
    output logic [W-1:0]  o_rd_real,
    output logic [W-1:0]  o_rd_imag,
    output logic [N*W-1:0] o_flat_real,
    output logic [N*W-1:0] o_flat_imag
);
    logic [2*W-1:0] r_mem [N];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < N; k++) r_mem[k] <= '0;
        end else if (i_load_en) begin
            for (int k = 0; k < N; k++) r_mem[k] <= {i_load_real[k*W +: W], i_load_imag[k*W +: W]};
        end else if (i_wr_en) begin
            r_mem[i_wr_idx] <= {i_wr_real, i_wr_imag};
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_flat
        assign o_flat_real[i*W +: W] = r_mem[i][2*W-1:W];
        assign o_flat_imag[i*W +: W] = r_mem[i][W-1:0];
    end

    assign {o_rd_real, o_rd_imag} = r_mem[i_rd_idx];
endmodule

// File: rtl/fft_frame_streamer.sv
// fft_frame_streamer: gathers serial samples into a frame for the parallel FFT core,
// runs the core once, then streams the result out in natural or bit-reversed order.
module fft_frame_streamer import fft_pkg::*; #(
    parameter int FORMAT_WIDTH   = fft_pkg::FORMAT_WIDTH,
    parameter int MAX_POINTS     = 32,
    parameter int SIZE_WIDTH     = 11,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic [SIZE_WIDTH-1:0]          i_cfg_size,
    input  logic                           i_cfg_bitrev,
    input  logic                           i_in_valid,
    output logic                           o_in_ready,
    input  logic [FORMAT_WIDTH-1:0]        i_in_real,
    input  logic [FORMAT_WIDTH-1:0]        i_in_imag,
    output logic [SIZE_WIDTH-1:0]          o_core_fft_size,
    output logic                           o_core_fft_start,
    output logic [MAX_POINTS*FORMAT_WIDTH-1:0] o_core_input_real,
    output logic [MAX_POINTS*FORMAT_WIDTH-1:0] o_core_input_imag,
    input  logic                           i_core_fft_done,
    input  logic [MAX_POINTS*FORMAT_WIDTH-1:0] i_core_output_real,
    input  logic [MAX_POINTS*FORMAT_WIDTH-1:0] i_core_output_imag,
    output logic                           o_out_valid,
    input  logic                           i_out_ready,
    output logic [FORMAT_WIDTH-1:0]        o_out_real,
    output logic [FORMAT_WIDTH-1:0]        o_out_imag,
    output logic                           o_out_last,
    output logic                           o_err_size,
    output logic                           o_err_timeout,
    output logic [15:0]                    o_frame_count
);
    localparam int FW = FORMAT_WIDTH;
    localparam int BW = MAX_POINTS * FW;
    localparam int IW = $clog2(MAX_POINTS);
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    state_t                r_state, w_next;
    logic [IW-1:0]         r_wr_idx, r_rd_idx, w_out_idx;
    logic [SIZE_WIDTH-1:0] r_size, w_size, w_cur_size;
    logic [7:0]            r_log2;
    logic                  r_bitrev, r_err_size, r_err_timeout;
    logic [TW-1:0]         r_tmo;
    logic [15:0]           r_frame_count;
    logic                  w_load, w_wait, w_unload, w_acc, w_first, w_legal;
    logic                  w_wr_last, w_rd_last, w_cap, w_to;
    logic [BW-1:0]         w_in_flat_real, w_in_flat_imag, w_out_flat_real, w_out_flat_imag;
    logic [FW-1:0]         w_in_rd_real, w_in_rd_imag;

    assign w_load     = r_state == LOAD;
    assign w_wait     = r_state == WAIT;
    assign w_unload   = r_state == UNLOAD;
    assign w_acc      = w_load && i_in_valid;
    assign w_first    = w_acc && r_wr_idx == '0;
    assign w_legal    = is_legal_size(32'(i_cfg_size), 32'(MAX_POINTS));
    assign w_size     = w_legal ? i_cfg_size : SIZE_WIDTH'(MAX_POINTS);
    assign w_cur_size = w_first ? w_size : r_size;
    assign w_wr_last  = w_acc && 32'(r_wr_idx) == 32'(w_cur_size) - 32'd1;
    assign w_rd_last  = 32'(r_rd_idx) == 32'(r_size) - 32'd1;
    assign w_cap      = w_wait && i_core_fft_done;
    assign w_to       = w_wait && !i_core_fft_done && r_tmo == TW'(TIMEOUT_CYCLES - 1);
    assign w_out_idx  = r_bitrev ? IW'(bitrev(32'(r_rd_idx), r_log2)) : r_rd_idx;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= LOAD;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            LOAD:    w_next = w_wr_last ? START : LOAD;
            START:   w_next = WAIT;
            WAIT:    w_next = i_core_fft_done ? UNLOAD : (w_to ? LOAD : WAIT);
            UNLOAD:  w_next = (i_out_ready && w_rd_last) ? LOAD : UNLOAD;
            default: w_next = LOAD;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_idx      <= '0;
            r_rd_idx      <= '0;
            r_size        <= SIZE_WIDTH'(MAX_POINTS);
            r_log2        <= '0;
            r_bitrev      <= 1'b0;
            r_err_size    <= 1'b0;
            r_err_timeout <= 1'b0;
            r_tmo         <= '0;
            r_frame_count <= '0;
        end else begin
            if (w_acc) r_wr_idx <= w_wr_last ? '0 : r_wr_idx + IW'(1);
            else if (w_to) r_wr_idx <= '0;
            if (w_first) begin
                r_size   <= w_size;
                r_log2   <= size_log2(32'(w_size));
                r_bitrev <= i_cfg_bitrev;
                if (!w_legal) r_err_size <= 1'b1;
            end
            r_tmo <= w_wait ? r_tmo + TW'(1) : '0;
            if (w_to) r_err_timeout <= 1'b1;
            if (w_unload && i_out_ready) begin
                r_rd_idx <= w_rd_last ? '0 : r_rd_idx + IW'(1);
                if (w_rd_last) r_frame_count <= r_frame_count + 16'd1;
            end
        end
    end

    frame_buffer #(.W(FW), .N(MAX_POINTS), .IW(IW)) u_in_buf (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_wr_en(w_acc), .i_wr_idx(r_wr_idx), .i_wr_real(i_in_real), .i_wr_imag(i_in_imag),
        .i_load_en(1'b0), .i_load_real('0), .i_load_imag('0),
        .i_rd_idx('0), .o_rd_real(w_in_rd_real), .o_rd_imag(w_in_rd_imag),
        .o_flat_real(w_in_flat_real), .o_flat_imag(w_in_flat_imag)
    );

    frame_buffer #(.W(FW), .N(MAX_POINTS), .IW(IW)) u_out_buf (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_wr_en(1'b0), .i_wr_idx('0), .i_wr_real('0), .i_wr_imag('0),
        .i_load_en(w_cap), .i_load_real(i_core_output_real), .i_load_imag(i_core_output_imag),
        .i_rd_idx(w_out_idx), .o_rd_real(o_out_real), .o_rd_imag(o_out_imag),
        .o_flat_real(w_out_flat_real), .o_flat_imag(w_out_flat_imag)
    );

    // The input buffer is untouched between a frame's last accept and the next frame's
    // first accept, so the core buses stay stable for the whole START/WAIT window.
    for (genvar i = 0; i < MAX_POINTS; i++) begin : g_core_bus
        assign o_core_input_real[i*FW +: FW] = (32'(i) < 32'(r_size)) ? w_in_flat_real[i*FW +: FW] : '0;
        assign o_core_input_imag[i*FW +: FW] = (32'(i) < 32'(r_size)) ? w_in_flat_imag[i*FW +: FW] : '0;
    end

    assign o_in_ready       = w_load;
    assign o_core_fft_start = r_state == START;
    assign o_core_fft_size  = r_size;
    assign o_out_valid      = w_unload;
    assign o_out_last       = w_unload && w_rd_last;
    assign o_err_size       = r_err_size;
    assign o_err_timeout    = r_err_timeout;
    assign o_frame_count    = r_frame_count;
endmodule

// File: tb/tb_fft_frame_streamer.sv
// tb_fft_frame_streamer: table-driven and randomized frames against an echoing core model
// and an index-order reference model.
module tb_fft_frame_streamer;
    localparam int FW = 9;
    localparam int NP = 32;
    localparam int SW = 11;
    localparam int BW = NP * FW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [SW-1:0] cfg_size;
    logic          cfg_bitrev, in_valid, in_ready, out_valid, out_ready, out_last;
    logic [FW-1:0] in_real, in_imag, out_real, out_imag;
    logic [SW-1:0] core_fft_size;
    logic          core_fft_start, core_fft_done, err_size, err_timeout;
    logic [BW-1:0] core_in_r, core_in_i, core_out_r, core_out_i;
    logic [15:0]   frame_count;

    always #5 clk = ~clk;

    fft_frame_streamer #(.FORMAT_WIDTH(FW), .MAX_POINTS(NP), .SIZE_WIDTH(SW), .TIMEOUT_CYCLES(4096)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_cfg_size(cfg_size), .i_cfg_bitrev(cfg_bitrev),
        .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_real(in_real), .i_in_imag(in_imag),
        .o_core_fft_size(core_fft_size), .o_core_fft_start(core_fft_start),
        .o_core_input_real(core_in_r), .o_core_input_imag(core_in_i),
        .i_core_fft_done(core_fft_done), .i_core_output_real(core_out_r), .i_core_output_imag(core_out_i),
        .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_real(out_real), .o_out_imag(out_imag),
        .o_out_last(out_last), .o_err_size(err_size), .o_err_timeout(err_timeout), .o_frame_count(frame_count)
    );

    int n_cmp = 0, n_bad = 0, exp_count = 0, core_delay = 10;
    bit core_never = 1'b0;
    logic [FW-1:0] sent_r [NP];
    logic [FW-1:0] sent_i [NP];

    typedef struct {
        logic [SW-1:0] size;
        bit            brev;
        int            eff;
        bit            err;
    } vec_t;
    vec_t vecs [9];

    task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int rev(input int k, input int bits);
        int r = 0, x = k;
        for (int b = 0; b < bits; b++) begin
            r = r * 2 + x % 2;
            x = x / 2;
        end
        return r;
    endfunction

    // Core model: holds junk on its result buses except during the done cycle,
    // when it echoes the frame it saw on the start pulse.
    initial begin
        logic [BW-1:0] cap_r, cap_i;
        int cnt = 0;
        core_fft_done = 1'b0;
        core_out_r = '0;
        core_out_i = '0;
        forever begin
            @(posedge clk);
            #2;
            core_fft_done = 1'b0;
            for (int k = 0; k < NP; k++) begin
                core_out_r[k*FW +: FW] = FW'($urandom);
                core_out_i[k*FW +: FW] = FW'($urandom);
            end
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    core_fft_done = 1'b1;
                    core_out_r = cap_r;
                    core_out_i = cap_i;
                end
            end
            if (core_fft_start && !core_never) begin
                cap_r = core_in_r;
                cap_i = core_in_i;
                cnt = core_delay;
            end
        end
    end

    task automatic send_frame(input logic [SW-1:0] cfg, input bit brev, input int eff, input int mode, input int gap_pct);
        logic [BW-1:0] er, ei;
        for (int k = 0; k < NP; k++) begin
            sent_r[k] = (k >= eff) ? '0 : (mode == 0) ? FW'(74 + (80 * k) / 31) : FW'($urandom);
            sent_i[k] = (k >= eff || mode == 0) ? '0 : FW'($urandom);
            er[k*FW +: FW] = sent_r[k];
            ei[k*FW +: FW] = sent_i[k];
        end
        for (int k = 0; k < eff; k++) begin
            cfg_size   = (k == 0) ? cfg : SW'($urandom);
            cfg_bitrev = (k == 0) ? brev : 1'($urandom);
            while (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
                in_valid = 1'b0;
                step();
            end
            chk("in_ready_load", 320'(in_ready), 320'(1));
            in_valid = 1'b1;
            in_real  = sent_r[k];
            in_imag  = sent_i[k];
            step();
        end
        in_valid = 1'b0;
        chk("start_latency", 320'(core_fft_start), 320'(1));
        chk("in_ready_start", 320'(in_ready), 320'(0));
        chk("core_fft_size", 320'(core_fft_size), 320'(eff));
        chk("core_bus_real", 320'(core_in_r), 320'(er));
        chk("core_bus_imag", 320'(core_in_i), 320'(ei));
        step();
        chk("start_one_cycle", 320'(core_fft_start), 320'(0));
    endtask

    task automatic recv_frame(input int eff, input bit brev, input int rdy_pct, input int abort_at);
        int lat = 1, lg = 0, k = 0, cyc = 0, j;
        while (!out_valid && lat < 400) begin
            step();
            lat++;
        end
        chk("done_to_valid", 320'(lat), 320'(core_delay + 1));
        while ((1 << lg) < eff) lg++;
        while (k < eff && cyc < 4000) begin
            if (k == abort_at) return;
            j = brev ? rev(k, lg) : k;
            chk("out_valid", 320'(out_valid), 320'(1));
            chk("out_word", 320'({out_real, out_imag, out_last}), 320'({sent_r[j], sent_i[j], k == eff - 1}));
            out_ready = int'($urandom_range(99)) < rdy_pct;
            step();
            if (out_ready) k++;
            cyc++;
        end
        out_ready = 1'b0;
        chk("unload_count", 320'(k), 320'(eff));
        exp_count++;
        chk("out_valid_after", 320'(out_valid), 320'(0));
        chk("in_ready_after", 320'(in_ready), 320'(1));
        chk("frame_count", 320'(frame_count), 320'(exp_count));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int w, eff;
        bit brev;
        vecs[0] = '{11'd32, 1'b0, 32, 1'b0};
        vecs[1] = '{11'd8,  1'b1, 8,  1'b0};
        vecs[2] = '{11'd4,  1'b1, 4,  1'b0};
        vecs[3] = '{11'd16, 1'b0, 16, 1'b0};
        vecs[4] = '{11'd16, 1'b1, 16, 1'b0};
        vecs[5] = '{11'd12, 1'b0, 32, 1'b1};
        vecs[6] = '{11'd0,  1'b1, 32, 1'b1};
        vecs[7] = '{11'd64, 1'b0, 32, 1'b1};
        vecs[8] = '{11'd8,  1'b0, 8,  1'b1};
        rst_n = 1'b0; cfg_size = '0; cfg_bitrev = 1'b0; in_valid = 1'b0;
        in_real = '0; in_imag = '0; out_ready = 1'b0;
        step();
        step();
        chk("rst_in_ready", 320'(in_ready), 320'(1));
        chk("rst_out_valid", 320'(out_valid), 320'(0));
        chk("rst_fft_size", 320'(core_fft_size), 320'(NP));
        chk("rst_start", 320'(core_fft_start), 320'(0));
        chk("rst_errs", 320'({err_size, err_timeout}), 320'(0));
        chk("rst_frame_count", 320'(frame_count), 320'(0));
        chk("rst_core_bus", 320'({core_in_r[31:0], core_in_i[31:0], out_real, out_imag, out_last}), 320'(0));
        rst_n = 1'b1;
        step();

        send_frame(11'd32, 1'b0, 32, 0, 0);
        recv_frame(32, 1'b0, 100, -1);

        for (int v = 0; v < 9; v++) begin
            send_frame(vecs[v].size, vecs[v].brev, vecs[v].eff, 1, 20);
            recv_frame(vecs[v].eff, vecs[v].brev, 70, -1);
            chk("err_size", 320'(err_size), 320'(vecs[v].err));
        end

        send_frame(11'd32, 1'b0, 32, 1, 0);
        recv_frame(32, 1'b0, 100, 5);
        #3 rst_n = 1'b0;
        #1;
        exp_count = 0;
        chk("midrst_out_valid", 320'(out_valid), 320'(0));
        chk("midrst_in_ready", 320'(in_ready), 320'(1));
        chk("midrst_state", 320'({frame_count, err_size, err_timeout, core_fft_size}), 320'({16'd0, 2'b00, 11'd32}));
        chk("midrst_core_bus", 320'(core_in_r | core_in_i), 320'(0));
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_in_ready", 320'(in_ready), 320'(1));
        chk("post_rst_frame_count", 320'(frame_count), 320'(0));

        for (int f = 0; f < 3; f++) begin
            eff  = 4 << $urandom_range(3);
            brev = 1'($urandom);
            send_frame(SW'(eff), brev, eff, 1, 40);
            recv_frame(eff, brev, 50, -1);
        end
        chk("three_frames", 320'(frame_count), 320'(3));

        core_never = 1'b1;
        send_frame(11'd32, 1'b0, 32, 1, 0);
        w = 1;
        while (!in_ready && w < 5000) begin
            chk("no_early_timeout", 320'(err_timeout), 320'(0));
            step();
            w++;
        end
        chk("timeout_cycles", 320'(w), 320'(4097));
        chk("err_timeout", 320'(err_timeout), 320'(1));
        chk("timeout_no_output", 320'({out_valid, frame_count}), 320'({1'b0, 16'(exp_count)}));
        core_never = 1'b0;
        send_frame(11'd16, 1'b1, 16, 1, 10);
        recv_frame(16, 1'b1, 50, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
